// File: rtl/ffn_argmax_pkg.sv
// Shared types and default network sizing for the arg-max classifier.
// Defaults mirror network_params.h so the vector packing matches the matmul stage.
package ffn_argmax_pkg;

    localparam int unsigned FFN_WIDTH_DEF    = 16;
    localparam int unsigned NUM_OUTPUT_N_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Class-index width; a single-class network still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ffn_argmax.sv
// Sequential arg-max over one captured vector of signed output-neuron scores,
// scanning one element per cycle; lowest index wins ties.
module ffn_argmax
    import ffn_argmax_pkg::*;
#(
    parameter int unsigned FFN_WIDTH    = FFN_WIDTH_DEF,
    parameter int unsigned NUM_OUTPUT_N = NUM_OUTPUT_N_DEF,
    parameter int unsigned IDX_W        = idx_width(NUM_OUTPUT_N)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [FFN_WIDTH*2*NUM_OUTPUT_N-1:0] output_neurons,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IDX_W-1:0]                  class_index,
    output logic [2*FFN_WIDTH-1:0]            class_score
);

    localparam int unsigned SW = 2 * FFN_WIDTH;
    localparam int unsigned VW = SW * NUM_OUTPUT_N;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUT_N - 1);

    state_e                  state_q, state_d;
    logic [VW-1:0]           vec_q, vec_d;
    logic signed [SW-1:0]    best_q, best_d;
    logic [IDX_W-1:0]        best_idx_q, best_idx_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        class_index_q, class_index_d;
    logic signed [SW-1:0]    class_score_q, class_score_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;

    logic signed [SW-1:0]    cur_score;
    logic signed [SW-1:0]    win_score;
    logic [IDX_W-1:0]        win_idx;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        cnt_d         = cnt_q;
        class_index_d = class_index_q;
        class_score_d = class_score_q;
        cur_score     = vec_q[SW*int'(cnt_q) +: SW];
        win_score     = best_q;
        win_idx       = best_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    vec_d      = output_neurons;
                    best_d     = output_neurons[SW-1:0];
                    best_idx_d = '0;
                    cnt_d      = IDX_W'(1);
                    if (NUM_OUTPUT_N == 1) begin
                        state_d       = ST_DONE;
                        class_index_d = '0;
                        class_score_d = output_neurons[SW-1:0];
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                // Strict compare keeps the earliest index on ties.
                if (cur_score > best_q) begin
                    win_score = cur_score;
                    win_idx   = cnt_q;
                end
                best_d     = win_score;
                best_idx_d = win_idx;
                cnt_d      = IDX_W'(cnt_q + 1'b1);
                if (cnt_q == LAST_IDX) begin
                    state_d       = ST_DONE;
                    class_index_d = win_idx;
                    class_score_d = win_score;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            vec_q         <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            cnt_q         <= '0;
            class_index_q <= '0;
            class_score_q <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            cnt_q         <= cnt_d;
            class_index_q <= class_index_d;
            class_score_q <= class_score_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign class_index = class_index_q;
    assign class_score = class_score_q;

endmodule

// File: tb/tb_ffn_argmax.sv
// Randomized self-checking bench for ffn_argmax against a max-then-first-match
// reference model.
module tb_ffn_argmax;

    localparam int FW = 16;
    localparam int N  = 10;
    localparam int IW = 4;
    localparam int SW = 2 * FW;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [FW*2*N-1:0] output_neurons;
    logic              out_valid;
    logic              out_ready;
    logic [IW-1:0]     class_index;
    logic [SW-1:0]     class_score;

    int checks = 0;
    int errors = 0;
    int vec[N];

    ffn_argmax #(.FFN_WIDTH(FW), .NUM_OUTPUT_N(N)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .output_neurons(output_neurons),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .class_index   (class_index),
        .class_score   (class_score)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [FW*2*N-1:0] pack_vec();
        logic [FW*2*N-1:0] p;
        for (int k = 0; k < N; k++) p[k*SW +: SW] = vec[k];
        return p;
    endfunction

    // Reference: find the maximum value, then the first position holding it.
    function automatic int ref_idx();
        int m;
        m = vec[0];
        for (int k = 1; k < N; k++) if (vec[k] > m) m = vec[k];
        for (int k = 0; k < N; k++) if (vec[k] == m) return k;
        return 0;
    endfunction

    function automatic void gen_vec(input int mode);
        int extremes[3];
        extremes[0] = int'(32'h8000_0000);
        extremes[1] = int'(32'h7FFF_FFFF);
        extremes[2] = int'(32'h8000_0001);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       vec[k] = int'($urandom_range(0, 6)) - 3;
                1:       vec[k] = int'($urandom());
                default: vec[k] = extremes[$urandom_range(0, 2)];
            endcase
        end
    endfunction

    task automatic run_vec(input string tag, input int hold, input bit noise);
        int lat;
        int ei;
        int es;
        ei = ref_idx();
        es = vec[ei];
        @(negedge clock);
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        check({tag, ".idle_ready"}, in_ready, 1);
        output_neurons = pack_vec();
        in_valid       = 1'b1;
        out_ready      = (hold == 0);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (noise) begin
                in_valid       = 1'($urandom_range(0, 1));
                output_neurons = {N{$urandom()}};
            end
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, lat, N - 1);
        check({tag, ".busy_ready"}, in_ready, 0);
        check({tag, ".idx"}, class_index, ei);
        check({tag, ".score"}, $signed(class_score), es);
        for (int c = 0; c < hold; c++) begin
            @(posedge clock);
            @(negedge clock);
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_idx"}, class_index, ei);
            check({tag, ".hold_score"}, $signed(class_score), es);
            check({tag, ".hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check({tag, ".post_valid"}, out_valid, 0);
        check({tag, ".post_ready"}, in_ready, 1);
        @(posedge clock);
        @(negedge clock);
        check({tag, ".no_reaccept"}, in_ready, 1);
        check({tag, ".kept_idx"}, class_index, ei);
    endtask

    task automatic stream();
        int q_idx[$];
        int q_sc[$];
        int fed = 0;
        int got = 0;
        int last_t = -1;
        int cyc = 0;
        int ei;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clock);
        while (got < 4 && cyc < 200) begin
            if (out_valid) begin
                if (q_idx.size() > 0) begin
                    check("stream.idx", class_index, q_idx.pop_front());
                    check("stream.score", $signed(class_score), q_sc.pop_front());
                end else begin
                    check("stream.unexpected", 1, 0);
                end
                if (last_t >= 0) check("stream.spacing", cyc - last_t, N + 1);
                last_t = cyc;
                got++;
            end
            if (in_ready) begin
                if (fed < 4) begin
                    gen_vec($urandom_range(0, 2));
                    ei = ref_idx();
                    q_idx.push_back(ei);
                    q_sc.push_back(vec[ei]);
                    output_neurons = pack_vec();
                    in_valid = 1'b1;
                    fed++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        in_valid = 1'b0;
        check("stream.count", got, 4);
    endtask

    task automatic reset_mid_scan();
        gen_vec(1);
        @(negedge clock);
        check("rst.pre_ready", in_ready, 1);
        output_neurons = pack_vec();
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst.valid", out_valid, 0);
        check("rst.ready", in_ready, 0);
        check("rst.idx", class_index, 0);
        check("rst.score", class_score, 0);
        @(posedge clock);
        @(negedge clock);
        check("rst.held_ready", in_ready, 0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst.release_ready", in_ready, 1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            @(negedge clock);
            check("rst.no_output", out_valid, 0);
        end
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        output_neurons = '0;
        #1;
        check("reset.valid", out_valid, 0);
        check("reset.ready", in_ready, 0);
        check("reset.idx", class_index, 0);
        check("reset.score", class_score, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        vec = '{3, -5, 7, 100, 2, 0, -1, 99, 4, 5};
        run_vec("basic", 0, 1'b0);

        for (int k = 0; k < N; k++) vec[k] = -7;
        run_vec("ties", 0, 1'b0);

        for (int k = 0; k < N; k++) vec[k] = int'(32'h8000_0000);
        vec[N-1] = int'(32'h8000_0001);
        run_vec("minval", 0, 1'b0);

        gen_vec(1);
        run_vec("backpressure", 20, 1'b0);

        gen_vec(0);
        run_vec("busy_noise", 0, 1'b1);

        for (int t = 0; t < 20; t++) begin
            gen_vec($urandom_range(0, 2));
            run_vec("random", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        stream();

        reset_mid_scan();
        gen_vec(1);
        run_vec("after_reset", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ffn_argmax.md
# ffn_argmax

Sequential arg-max classifier directly downstream of the single-layer feed-forward matrix multiply. Accepts one vector of `NUM_OUTPUT_N` signed output-neuron scores through a valid/ready handshake and scans it one element per cycle. Returns the index and value of the largest score through a second valid/ready handshake, producing the network's class decision for the softmax/classification path.

## Interface
Parameters:
- `FFN_WIDTH`, 16: base neuron width. Each score is `2*FFN_WIDTH` bits, signed two's complement.
- `NUM_OUTPUT_N`, 10: number of scores per vector. Must be ≥1.
- `IDX_W`, `$clog2(NUM_OUTPUT_N)` (minimum 1): width of the class index.

Ports:
- `clock` in 1: single clock; all state is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: the score vector is valid.
- `in_ready` out 1: the block can accept a vector.
- `output_neurons` in `FFN_WIDTH*2*NUM_OUTPUT_N`: score k occupies bits `[2*FFN_WIDTH*k + 2*FFN_WIDTH-1 : 2*FFN_WIDTH*k]`.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `class_index` out `IDX_W`: index of the maximum score.
- `class_score` out `2*FFN_WIDTH`: value of the maximum score, signed.

## Operation
- FSM has three states: IDLE, SCAN, DONE.
- Reset drives all outputs and state immediately:
  - state = IDLE
  - `out_valid` = 0, `in_ready` = 0 while `reset` is high
  - `class_index` = 0, `class_score` = 0
  - captured vector and scan counter cleared
- IDLE:
  - `in_ready` = 1 (when `reset` is low).
  - On `in_valid && in_ready`: capture the full vector into an internal register, set best = score0, best_idx = 0, cnt = 1.
  - Go to SCAN. If `NUM_OUTPUT_N` == 1, go straight to DONE.
- SCAN:
  - `in_ready` = 0 and `output_neurons` is ignored.
  - Each cycle compare captured score[cnt] against best as signed values.
  - Strictly greater replaces best and best_idx, so ties keep the lowest index.
  - cnt increments each cycle. The cycle that processes index `NUM_OUTPUT_N-1` transitions to DONE.
- DONE:
  - `out_valid` = 1.
  - `class_index` and `class_score` are stable and hold until the transfer.
  - On `out_valid && out_ready`: go to IDLE.
  - If `out_ready` is low, stay in DONE indefinitely with outputs unchanged.
- `class_index`/`class_score` keep their last value after the transfer until the next result loads. They are meaningful only while `out_valid` = 1.
- Reset asserted mid-SCAN or mid-DONE aborts the operation. The in-flight vector and result are discarded, with no partial output.
- An all-equal vector returns index 0.
- The most negative value (`-2^(2*FFN_WIDTH-1)`) compares correctly; no overflow is possible because the block only compares, never subtracts.

## Timing
- Input transfer occurs at edge t0. `out_valid` rises after edge t0+`NUM_OUTPUT_N`-1, which is t0 itself when `NUM_OUTPUT_N`=1.
- Output transfer occurs at edge t1. `in_ready` rises after t1. There is no same-cycle bypass from DONE to accept.
- Throughput with `out_ready` tied high is one vector per `NUM_OUTPUT_N`+1 cycles.
- Combinational paths:
  - `in_ready` and `out_valid` are decoded from registered state only.
  - There is no combinational path from `in_valid` or `out_ready` to any output.
- Critical path: one `2*FFN_WIDTH`-bit signed compare plus an `NUM_OUTPUT_N`:1 mux on the captured vector.

## Structure
- `FFN_WIDTH` and `NUM_OUTPUT_N` defaults come from `network_params.h`, shared with the matrix-multiply stage so that vector packing matches.
- FSM state encodings are localparams: IDLE=2'd0, SCAN=2'd1, DONE=2'd2. Unused code 2'd3 recovers to IDLE.
- No sub-module is required. The comparator and element-select mux stay inline.
- The captured vector is one packed register of `FFN_WIDTH*2*NUM_OUTPUT_N` bits.

## Test plan
All scenarios use `FFN_WIDTH`=16, `NUM_OUTPUT_N`=10.
- Basic max, scores {3,-5,7,100,2,0,-1,99,4,5}, `out_ready`=1:
  - Expect `class_index`=3, `class_score`=100.
  - `out_valid` high exactly 9 cycles after acceptance, for one cycle.
- Ties and negative values:
  - Scores all -7 → index 0, score -7.
  - Scores {-2^31, …, -2^31 at k=0..8, -2^31+1 at k=9} → index 9.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles after `out_valid`. `out_valid` and results stay stable and `in_ready` stays 0.
  - Raise `out_ready`: one transfer occurs, then `in_ready`=1 on the next cycle.
- Input ignored while busy:
  - Toggle `in_valid` and change `output_neurons` during SCAN.
  - Expect the result unaffected and no second acceptance.
- Back-to-back streaming:
  - Feed 4 vectors with `in_valid` and `out_ready` always high.
  - Expect 4 correct results spaced 11 cycles apart.
- Reset mid-SCAN:
  - Assert `reset` at scan index 5. Expect `out_valid` to stay 0, outputs to go to 0, and `in_ready` = 0 during reset and 1 after release.
  - A fresh vector then processes normally.
